tsn_gate_ctrl: RTL and testbench



---
 rtl/tsn_gate_ctrl.sv | 152 +++++++++++++++
 tb/tb_tsn_gate_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsn_gate_ctrl.sv
// tsn_gate_ctrl: cyclic gate-control-list controller for the 8 per-priority
// transmission gates feeding the strict-priority scheduler.
// Optional feature macro: GCL_GUARD_BAND_EN (guard band ahead of gate closes).
module tsn_gate_ctrl #(
  parameter int unsigned DUR_W        = 16,
  parameter int unsigned GUARD_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_gcl_wr,
  input  logic [2:0]       in_gcl_addr,
  input  logic [7:0]       in_gcl_mask,
  input  logic [DUR_W-1:0] in_gcl_dur,
  input  logic [3:0]       in_gcl_len,
  input  logic             in_gcl_enable,
  input  logic [7:0]       in_queue_valid,
  output logic [7:0]       out_gate_valid,
  output logic [7:0]       out_gate_state,
  output logic [2:0]       out_entry_idx,
  output logic             out_cycle_start,
  output logic             out_cfg_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [7:0]       mask_tbl [8];
  logic [DUR_W-1:0] dur_tbl  [8];
  logic [3:0]       len_q;
  logic [2:0]       idx;
  logic [DUR_W-1:0] cnt;
  logic             en_q;
  logic [7:0]       gate_state;
  logic [7:0]       gate_valid;
  logic             cycle_start;
  logic             cfg_err;

  logic             en_rise;
  logic             len_ok;
  logic             wr_ok;
  logic             last;
  logic [2:0]       nxt_idx;
  logic [7:0]       entry0_mask;
  logic [DUR_W-1:0] entry0_dur;
  logic [7:0]       gated;

  // Down-counter load value: an entry lasts max(dur,1) cycles.
  function automatic logic [DUR_W-1:0] to_cnt(input logic [DUR_W-1:0] d);
    return (d == '0) ? '0 : d - DUR_W'(1);
  endfunction

  // Decode of enable edge, length legality, next entry and entry-0 bypass.
  always_comb begin
    en_rise = in_gcl_enable & ~en_q;
    len_ok  = (in_gcl_len != 4'd0) && (in_gcl_len <= 4'd8);
    wr_ok   = in_gcl_wr && (state == ST_IDLE);
    last    = ({1'b0, idx} == (len_q - 4'd1));
    nxt_idx = last ? 3'd0 : idx + 3'd1;
    // A write to entry 0 in the same cycle as the start must be seen by the start.
    if (wr_ok && (in_gcl_addr == 3'd0)) begin
      entry0_mask = in_gcl_mask;
      entry0_dur  = in_gcl_dur;
    end else begin
      entry0_mask = mask_tbl[0];
      entry0_dur  = dur_tbl[0];
    end
  end

  // Gate list table; writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        mask_tbl[i] <= 8'hFF;
        dur_tbl[i]  <= DUR_W'(1);
      end
    end else if (wr_ok) begin
      mask_tbl[in_gcl_addr] <= in_gcl_mask;
      dur_tbl[in_gcl_addr]  <= in_gcl_dur;
    end
  end

  // IDLE/RUN sequencer: entry stepping, cycle-start and config-error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      len_q       <= 4'd1;
      idx         <= '0;
      cnt         <= '0;
      en_q        <= 1'b0;
      gate_state  <= '1;
      cycle_start <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      en_q        <= in_gcl_enable;
      cycle_start <= 1'b0;
      cfg_err     <= in_gcl_wr && (state == ST_RUN);
      if (state == ST_IDLE) begin
        gate_state <= '1;
        idx        <= '0;
        if (en_rise) begin
          if (len_ok) begin
            state       <= ST_RUN;
            len_q       <= in_gcl_len;
            gate_state  <= entry0_mask;
            cnt         <= to_cnt(entry0_dur);
            cycle_start <= 1'b1;
          end else begin
            cfg_err <= 1'b1;
          end
        end
      end else begin
        if (!in_gcl_enable) begin
          state      <= ST_IDLE;
          gate_state <= '1;
          idx        <= '0;
          cnt        <= '0;
        end else if (cnt != '0) begin
          cnt <= cnt - DUR_W'(1);
        end else begin
          idx         <= nxt_idx;
          gate_state  <= mask_tbl[nxt_idx];
          cnt         <= to_cnt(dur_tbl[nxt_idx]);
          cycle_start <= last;
        end
      end
    end
  end

  // Queue-valid gating ahead of the output register.
  always_comb begin
    gated = in_queue_valid & gate_state;
`ifdef GCL_GUARD_BAND_EN
    // Table is frozen in RUN, so gate_state equals the current entry's mask.
    if ((state == ST_RUN) && (32'(cnt) < 32'(GUARD_CYCLES)))
      gated = gated & ~(gate_state & ~mask_tbl[nxt_idx]);
`endif
  end

  // Registered gated valid to the scheduler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gate_valid <= '0;
    else        gate_valid <= gated;
  end

  assign out_gate_valid  = gate_valid;
  assign out_gate_state  = gate_state;
  assign out_entry_idx   = idx;
  assign out_cycle_start = cycle_start;
  assign out_cfg_err     = cfg_err;

endmodule

// File: tb/tb_tsn_gate_ctrl.sv
// tb_tsn_gate_ctrl: directed and randomized checks of tsn_gate_ctrl against a
// schedule model based on elapsed time within the programmed cycle.
module tb_tsn_gate_ctrl;

  localparam int DUR_W = 16;
`ifdef GCL_GUARD_BAND_EN
  localparam int GUARD = 3;
`else
  localparam int GUARD = 64;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_gcl_wr = 1'b0;
  logic [2:0]       in_gcl_addr = '0;
  logic [7:0]       in_gcl_mask = '0;
  logic [DUR_W-1:0] in_gcl_dur = '0;
  logic [3:0]       in_gcl_len = '0;
  logic             in_gcl_enable = 1'b0;
  logic [7:0]       in_queue_valid = '0;
  logic [7:0]       out_gate_valid;
  logic [7:0]       out_gate_state;
  logic [2:0]       out_entry_idx;
  logic             out_cycle_start;
  logic             out_cfg_err;

  tsn_gate_ctrl #(.DUR_W(DUR_W), .GUARD_CYCLES(GUARD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_gcl_wr      (in_gcl_wr),
    .in_gcl_addr    (in_gcl_addr),
    .in_gcl_mask    (in_gcl_mask),
    .in_gcl_dur     (in_gcl_dur),
    .in_gcl_len     (in_gcl_len),
    .in_gcl_enable  (in_gcl_enable),
    .in_queue_valid (in_queue_valid),
    .out_gate_valid (out_gate_valid),
    .out_gate_state (out_gate_state),
    .out_entry_idx  (out_entry_idx),
    .out_cycle_start(out_cycle_start),
    .out_cfg_err    (out_cfg_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: table contents, running flag, cycles since run start, latched length.
  logic [7:0] m_mask [8];
  int         m_dur  [8];
  bit         m_run;
  int         m_t;
  int         m_len;
  bit         m_en_prev;

  function automatic int eff(int d);
    return (d == 0) ? 1 : d;
  endfunction

  // What the outputs should show for the model's current position in the cycle.
  task automatic model_view(output logic [7:0] g, output logic [2:0] ix,
                            output logic cs, output logic [7:0] closing);
    int total, p, acc, rem, k, nx;
    g = 8'hFF; ix = 3'd0; cs = 1'b0; closing = 8'h00;
    if (m_run) begin
      total = 0;
      for (int i = 0; i < m_len; i++) total += eff(m_dur[i]);
      p = m_t % total;
      acc = 0; k = 0; rem = 1;
      for (int i = 0; i < m_len; i++) begin
        if (p < acc + eff(m_dur[i])) begin
          k = i; rem = acc + eff(m_dur[i]) - p;
          break;
        end
        acc += eff(m_dur[i]);
      end
      nx = (k + 1) % m_len;
      g  = m_mask[k];
      ix = 3'(k);
      cs = (p == 0);
      if (rem - 1 < GUARD) closing = g & ~m_mask[nx];
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mask[i] = 8'hFF;
      m_dur[i]  = 1;
    end
    m_run = 0; m_t = 0; m_len = 1; m_en_prev = 0;
  endtask

  // One clock: predict, clock, then compare all outputs 1 time unit later.
  task automatic tick();
    logic [7:0] g0, c0, g1, c1, gv_exp;
    logic [2:0] i0, i1;
    logic       s0, s1;
    bit         err;
    model_view(g0, i0, s0, c0);
    gv_exp = in_queue_valid & g0;
`ifdef GCL_GUARD_BAND_EN
    gv_exp = gv_exp & ~c0;
`endif
    err = 0;
    @(posedge clk);
    if (m_run) begin
      if (in_gcl_wr) err = 1;
      if (!in_gcl_enable) m_run = 0;
      else m_t++;
    end else begin
      if (in_gcl_wr) begin
        m_mask[in_gcl_addr] = in_gcl_mask;
        m_dur[in_gcl_addr]  = int'(in_gcl_dur);
      end
      if (in_gcl_enable && !m_en_prev) begin
        if (in_gcl_len >= 1 && in_gcl_len <= 8) begin
          m_run = 1; m_t = 0; m_len = int'(in_gcl_len);
        end else begin
          err = 1;
        end
      end
    end
    m_en_prev = in_gcl_enable;
    model_view(g1, i1, s1, c1);
    #1;
    check("gate_state", out_gate_state, g1);
    check("entry_idx", {5'd0, out_entry_idx}, {5'd0, i1});
    check("cycle_start", {7'd0, out_cycle_start}, {7'd0, s1});
    check("cfg_err", {7'd0, out_cfg_err}, {7'd0, err});
    check("gate_valid", out_gate_valid, gv_exp);
  endtask

  task automatic write_entry(input int a, input logic [7:0] m, input int d);
    in_gcl_wr = 1'b1; in_gcl_addr = 3'(a); in_gcl_mask = m; in_gcl_dur = DUR_W'(d);
    tick();
    in_gcl_wr = 1'b0;
  endtask

  // Asynchronous reset applied between clock edges; outputs checked at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_gate_state", out_gate_state, 8'hFF);
    check("rst_entry_idx", {5'd0, out_entry_idx}, 8'h00);
    check("rst_cycle_start", {7'd0, out_cycle_start}, 8'h00);
    check("rst_cfg_err", {7'd0, out_cfg_err}, 8'h00);
    check("rst_gate_valid", out_gate_valid, 8'h00);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_cnt;
    bit found;
    logic [7:0] vg, vc;
    logic [2:0] vi;
    logic       vs;

    #1;
    do_reset();

    // Gates all open while disabled.
    in_queue_valid = 8'hA5;
    repeat (3) tick();
    check("idle_gate_valid_a5", out_gate_valid, 8'hA5);

    // Two-entry list: 01 for 10 cycles, FE for 5 cycles.
    write_entry(0, 8'h01, 10);
    write_entry(1, 8'hFE, 5);
    in_gcl_len = 4'd2; in_gcl_enable = 1'b1;
    cs_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      in_queue_valid = 8'($urandom);
      tick();
      if (out_cycle_start) cs_cnt++;
    end
    check("cycle_start_count_45", 8'(cs_cnt), 8'd3);

    // Write attempt while running is rejected.
    write_entry(1, 8'h00, 3);
    repeat (20) tick();

    // Disable in the middle of entry 1.
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      model_view(vg, vi, vs, vc);
      if (vi == 3'd1) found = 1;
    end
    check("reached_entry1", {7'd0, found}, 8'd1);
    tick();
    in_gcl_enable = 1'b0;
    repeat (3) tick();
    check("disable_gate_ff", out_gate_state, 8'hFF);

    // Illegal lengths 0 and 9.
    in_gcl_len = 4'd0; in_gcl_enable = 1'b1;
    repeat (4) tick();
    in_gcl_enable = 1'b0; tick();
    in_gcl_len = 4'd9; in_gcl_enable = 1'b1;
    repeat (3) tick();
    in_gcl_enable = 1'b0; tick();

    // Zero duration with a one-entry list.
    write_entry(0, 8'h5A, 0);
    in_gcl_len = 4'd1; in_gcl_enable = 1'b1;
    repeat (5) tick();
    check("dur0_cycle_start", {7'd0, out_cycle_start}, 8'd1);
    in_gcl_enable = 1'b0; tick();

    // Write to entry 0 coinciding with the enable rise.
    in_gcl_enable = 1'b1;
    write_entry(0, 8'h3C, 2);
    check("same_cycle_wr_mask", out_gate_state, 8'h3C);
    repeat (6) tick();
    in_gcl_enable = 1'b0; tick();

    // Reset in the middle of a run, then the reset table runs.
    in_gcl_len = 4'd2; in_gcl_enable = 1'b1;
    repeat (7) tick();
    in_gcl_enable = 1'b0;
    do_reset();
    tick();
    in_gcl_len = 4'd8; in_gcl_enable = 1'b1;
    repeat (20) tick();
    in_gcl_enable = 1'b0; tick();

`ifdef GCL_GUARD_BAND_EN
    // Guard band ahead of the close of queues 4..7.
    write_entry(0, 8'hFF, 10);
    write_entry(1, 8'h0F, 10);
    in_queue_valid = 8'hFF; in_gcl_len = 4'd2; in_gcl_enable = 1'b1;
    repeat (25) tick();
    in_gcl_enable = 1'b0; tick();
`endif

    // Randomized lists, with occasional rejected writes and illegal lengths.
    for (int r = 0; r < 8; r++) begin
      for (int e = 0; e < 8; e++)
        if ($urandom_range(0, 3) != 0)
          write_entry(e, 8'($urandom), int'($urandom_range(0, 6)));
      in_gcl_len = 4'($urandom_range(0, 10));
      in_gcl_enable = 1'b1;
      for (int i = 0; i < int'($urandom_range(10, 60)); i++) begin
        in_queue_valid = 8'($urandom);
        in_gcl_wr = ($urandom_range(0, 15) == 0);
        in_gcl_addr = 3'($urandom);
        tick();
        in_gcl_wr = 1'b0;
      end
      in_gcl_enable = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
